// File: rtl/hdmi_tx_timing_if.sv
`default_nettype none
// ============================================================================
// hdmi_tx_timing_if : ADV FIFO side inputs and transmitter side outputs
// Rev 1.0
// ============================================================================
interface hdmi_tx_timing_if;
  logic        en;
  logic [23:0] fifo_q;
  logic        rdempty_adv;
  logic        HDMI_TX_DE;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_start;
  logic        line_start;
  logic        vid_de;
  logic        vid_hs;
  logic        vid_vs;
  logic [23:0] vid_d;
  logic        running;
  logic [15:0] underflow_cnt;

  modport master (
    output en, fifo_q, rdempty_adv,
    input  HDMI_TX_DE, h_cnt, v_cnt, frame_start, line_start,
           vid_de, vid_hs, vid_vs, vid_d, running, underflow_cnt
  );

  modport slave (
    input  en, fifo_q, rdempty_adv,
    output HDMI_TX_DE, h_cnt, v_cnt, frame_start, line_start,
           vid_de, vid_hs, vid_vs, vid_d, running, underflow_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hdmi_tx_timing.sv
`default_nettype none
// ============================================================================
// hdmi_tx_timing : pixel-clock video timing generator and ADV output stage
// Rev 1.0
// ============================================================================
module hdmi_tx_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [23:0] UF_COLOR = 24'hFF00FF
) (
  input  logic            clk,
  input  logic            reset,
  hdmi_tx_timing_if.slave tx
);
  localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        w_running;
  logic        w_h_end;
  logic        w_v_end;
  logic        w_frame_end;
  logic        w_de0;
  logic        w_hs0;
  logic        w_vs0;
  logic        r_vid_de;
  logic        r_vid_hs;
  logic        r_vid_vs;
  logic        r_uf_d;
  logic [15:0] r_uf_cnt;

  assign w_running   = (r_state != ST_IDLE);
  assign w_h_end     = (r_h_cnt == c_h_last);
  assign w_v_end     = (r_v_cnt == c_v_last);
  assign w_frame_end = w_h_end & w_v_end;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // DRAIN finishes the current frame; re-enabling resumes without touching counters
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (tx.en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!tx.en) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (tx.en)            w_state_nxt = ST_RUN;
        else if (w_frame_end) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_running) begin
      if (w_h_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_end ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  assign w_de0 = w_running & (r_h_cnt < c_h_active) & (r_v_cnt < c_v_active);
  assign w_hs0 = w_running & (r_h_cnt >= c_hs_start) & (r_h_cnt < c_hs_end);
  assign w_vs0 = w_running & (r_v_cnt >= c_vs_start) & (r_v_cnt < c_vs_end);

  // Stage 1 lines up with the one-clock FIFO read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_de <= 1'b0;
      r_vid_hs <= ~SYNC_POL;
      r_vid_vs <= ~SYNC_POL;
      r_uf_d   <= 1'b0;
    end else begin
      r_vid_de <= w_de0;
      r_vid_hs <= w_hs0 ? SYNC_POL : ~SYNC_POL;
      r_vid_vs <= w_vs0 ? SYNC_POL : ~SYNC_POL;
      r_uf_d   <= w_de0 & tx.rdempty_adv;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_uf_cnt <= '0;
    else if (w_de0 && tx.rdempty_adv && (r_uf_cnt != 16'hFFFF))
      r_uf_cnt <= r_uf_cnt + 16'd1;
  end

  assign tx.HDMI_TX_DE    = w_de0;
  assign tx.h_cnt         = r_h_cnt;
  assign tx.v_cnt         = r_v_cnt;
  assign tx.frame_start   = w_running & (r_h_cnt == 10'd0) & (r_v_cnt == 10'd0);
  assign tx.line_start    = w_running & (r_h_cnt == 10'd0);
  assign tx.vid_de        = r_vid_de;
  assign tx.vid_hs        = r_vid_hs;
  assign tx.vid_vs        = r_vid_vs;
  assign tx.vid_d         = !r_vid_de ? 24'h000000 : (r_uf_d ? UF_COLOR : tx.fifo_q);
  assign tx.running       = w_running;
  assign tx.underflow_cnt = r_uf_cnt;
endmodule
`default_nettype wire
